spi_reg_slave: RTL and testbench

//   Oversampled SPI mode-0 slave: host SPI pins sampled in the SPI_CLK domain; frames decoded into

---
 rtl/spi_reg_slave_if.sv | 40 ++++
 rtl/spi_reg_slave.sv | 194 +++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_slave_if
// Description : Bundles the host SPI pins and the register-file strobe bus of
//               spi_reg_slave.
//               slave  modport : seen by spi_reg_slave
//               master modport : seen by the host + register file side
//   SCLK_fromHost / SCSN_fromHost / MOSI_fromHost : host pins (async)
//   MISO_toHost                                   : registered host data out
//   reg_addr[6:0], reg_wdata[7:0]                 : register address / data
//   write_strobe, read_strobe                     : one-cycle requests
//   reg_rdata[7:0]                                : read data, 1 cycle latency
//   frame_active                                  : frame in progress
// Revision    : 1.0  initial release
// ============================================================================
interface spi_reg_slave_if;
  logic       SCLK_fromHost;
  logic       SCSN_fromHost;
  logic       MOSI_fromHost;
  logic       MISO_toHost;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] reg_rdata;
  logic       frame_active;

  modport slave (
    input  SCLK_fromHost, SCSN_fromHost, MOSI_fromHost, reg_rdata,
    output MISO_toHost, reg_addr, reg_wdata, write_strobe, read_strobe,
           frame_active
  );

  modport master (
    output SCLK_fromHost, SCSN_fromHost, MOSI_fromHost, reg_rdata,
    input  MISO_toHost, reg_addr, reg_wdata, write_strobe, read_strobe,
           frame_active
  );
endinterface
`default_nettype wire

// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_slave
// Description : Oversampled SPI mode-0 register slave. Host pins are
//               synchronized into SPI_CLK, edges detected, and frames of
//               {RW, ADDR[6:0]} + N data bytes (MSB first) are turned into
//               register write/read strobes with optional auto-increment.
// Ports       : SPI_CLK     - oversampling clock, rising edge
//               EXT_RESET_N - asynchronous active-low reset
//               bus         - spi_reg_slave_if.slave (host pins + reg bus)
// Revision    : 1.0  initial release
// ============================================================================
module spi_reg_slave #(
  parameter int SYNC_STAGES = 2,
  parameter bit AUTO_INC    = 1'b1
) (
  input  logic           SPI_CLK,
  input  logic           EXT_RESET_N,
  spi_reg_slave_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    RD_LOAD = 2'd2,
    DATA    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Input synchronizers and edge-detect history. Everything resets to 0,
  // including chip select, so a SCSN held low through reset release never
  // looks like a falling edge.
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_csn_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_csn_d;

  logic w_sclk_s;
  logic w_csn_s;
  logic w_mosi_s;
  logic w_rise;
  logic w_fall;
  logic w_csn_fall;

  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx;        // bits received so far in the current byte
  logic [6:0] r_tx;        // read bits still to be presented after MISO
  logic       r_rw;
  logic       r_miso;
  logic [6:0] r_reg_addr;
  logic [7:0] r_reg_wdata;
  logic       r_write_strobe;
  logic       r_read_strobe;

  logic [7:0] w_byte;
  logic       w_byte_done;

  always_ff @(posedge SPI_CLK or negedge EXT_RESET_N) begin
    if (!EXT_RESET_N) begin
      r_sclk_sync <= '0;
      r_csn_sync  <= '0;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_csn_d     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.SCLK_fromHost};
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0],  bus.SCSN_fromHost};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.MOSI_fromHost};
      r_sclk_d    <= w_sclk_s;
      r_csn_d     <= w_csn_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_csn_s     = r_csn_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise      =  w_sclk_s & ~r_sclk_d;
  assign w_fall      = ~w_sclk_s &  r_sclk_d;
  assign w_csn_fall  = ~w_csn_s  &  r_csn_d;

  // Byte as it will look after the current rising edge is shifted in.
  assign w_byte      = {r_rx, w_mosi_s};
  assign w_byte_done = w_rise && (r_bit_cnt == 3'd7);

  always_ff @(posedge SPI_CLK or negedge EXT_RESET_N) begin
    if (!EXT_RESET_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A read request spends its strobe cycle in CMD/DATA; RD_LOAD is the
  // following cycle, when the register file's data is valid.
  always_comb begin
    w_state_next = r_state;
    if (w_csn_s) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_csn_fall) w_state_next = CMD;
        CMD: begin
          if (r_read_strobe) begin
            w_state_next = RD_LOAD;
          end else if (w_byte_done && !w_byte[7]) begin
            w_state_next = DATA;
          end
        end
        RD_LOAD: w_state_next = DATA;
        DATA:    if (r_read_strobe) w_state_next = RD_LOAD;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge SPI_CLK or negedge EXT_RESET_N) begin
    if (!EXT_RESET_N) begin
      r_bit_cnt      <= 3'd0;
      r_rx           <= 7'd0;
      r_tx           <= 7'd0;
      r_rw           <= 1'b0;
      r_miso         <= 1'b0;
      r_reg_addr     <= 7'd0;
      r_reg_wdata    <= 8'd0;
      r_write_strobe <= 1'b0;
      r_read_strobe  <= 1'b0;
    end else begin
      r_write_strobe <= 1'b0;
      r_read_strobe  <= 1'b0;

      // Writes present the current address with the strobe, then advance.
      if (r_write_strobe && AUTO_INC) begin
        r_reg_addr <= r_reg_addr + 7'd1;
      end

      if (w_csn_s) begin
        r_bit_cnt <= 3'd0;
        r_miso    <= 1'b0;
      end else begin
        case (r_state)
          CMD: begin
            if (w_rise) begin
              r_rx      <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_reg_addr    <= w_byte[6:0];
                r_rw          <= w_byte[7];
                r_read_strobe <= w_byte[7];
              end
            end
          end
          RD_LOAD: begin
            r_tx   <= bus.reg_rdata[6:0];
            r_miso <= bus.reg_rdata[7];
          end
          DATA: begin
            if (w_rise) begin
              r_rx      <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (r_rw) begin
                  // Reads advance first so the prefetch targets the next byte.
                  r_reg_addr    <= r_reg_addr + {6'd0, AUTO_INC};
                  r_read_strobe <= 1'b1;
                end else begin
                  r_reg_wdata    <= w_byte;
                  r_write_strobe <= 1'b1;
                end
              end
            end else if (w_fall && r_rw && (r_bit_cnt != 3'd0)) begin
              // The fall right after a byte boundary keeps the freshly
              // loaded MSB on MISO for the host's first sample.
              r_miso <= r_tx[6];
              r_tx   <= {r_tx[5:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.MISO_toHost  = r_miso;
  assign bus.reg_addr     = r_reg_addr;
  assign bus.reg_wdata    = r_reg_wdata;
  assign bus.write_strobe = r_write_strobe;
  assign bus.read_strobe  = r_read_strobe;
  assign bus.frame_active = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_slave
// Description : Self-checking bench for spi_reg_slave. Two instances share
//               the host pins: one with AUTO_INC=1, one with AUTO_INC=0.
//               A register-file model answers reads with ~addr one cycle
//               after read_strobe. Directed frame table, abort, reset
//               mid-frame and randomized 8:1 frames.
// Revision    : 1.0  initial release
// ============================================================================
module tb_spi_reg_slave;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sclk  = 1'b0;
  logic csn   = 1'b1;
  logic mosi  = 1'b0;
  int   hp    = 50;      // SCLK half period in ns (SPI_CLK period 10 ns)

  always #5 clk = ~clk;

  spi_reg_slave_if bus_inc();
  spi_reg_slave_if bus_hold();

  assign bus_inc.SCLK_fromHost  = sclk;
  assign bus_inc.SCSN_fromHost  = csn;
  assign bus_inc.MOSI_fromHost  = mosi;
  assign bus_hold.SCLK_fromHost = sclk;
  assign bus_hold.SCSN_fromHost = csn;
  assign bus_hold.MOSI_fromHost = mosi;

  spi_reg_slave #(.SYNC_STAGES(2), .AUTO_INC(1'b1)) dut_inc (
    .SPI_CLK(clk), .EXT_RESET_N(rst_n), .bus(bus_inc.slave));
  spi_reg_slave #(.SYNC_STAGES(2), .AUTO_INC(1'b0)) dut_hold (
    .SPI_CLK(clk), .EXT_RESET_N(rst_n), .bus(bus_hold.slave));

  // Register file model: data valid only in the cycle after the strobe.
  always @(posedge clk) begin
    bus_inc.reg_rdata  <= bus_inc.read_strobe  ? ~{1'b0, bus_inc.reg_addr}  : 8'h00;
    bus_hold.reg_rdata <= bus_hold.read_strobe ? ~{1'b0, bus_hold.reg_addr} : 8'h00;
  end

  // Strobe monitors (sampled mid-cycle).
  logic [14:0] wq_inc[$], wq_hold[$];
  logic [6:0]  rq_inc[$], rq_hold[$];
  int   viol_inc = 0, viol_hold = 0, mhi_inc = 0, mhi_hold = 0;
  logic pw_inc = 1'b0, pr_inc = 1'b0, pw_hold = 1'b0, pr_hold = 1'b0;

  always @(negedge clk) begin
    if (bus_inc.write_strobe) wq_inc.push_back({bus_inc.reg_addr, bus_inc.reg_wdata});
    if (bus_inc.read_strobe)  rq_inc.push_back(bus_inc.reg_addr);
    if ((bus_inc.write_strobe && bus_inc.read_strobe) ||
        (bus_inc.write_strobe && pw_inc) || (bus_inc.read_strobe && pr_inc)) viol_inc++;
    pw_inc = bus_inc.write_strobe;
    pr_inc = bus_inc.read_strobe;
    if (bus_inc.MISO_toHost === 1'b1) mhi_inc++;

    if (bus_hold.write_strobe) wq_hold.push_back({bus_hold.reg_addr, bus_hold.reg_wdata});
    if (bus_hold.read_strobe)  rq_hold.push_back(bus_hold.reg_addr);
    if ((bus_hold.write_strobe && bus_hold.read_strobe) ||
        (bus_hold.write_strobe && pw_hold) || (bus_hold.read_strobe && pr_hold)) viol_hold++;
    pw_hold = bus_hold.write_strobe;
    pr_hold = bus_hold.read_strobe;
    if (bus_hold.MISO_toHost === 1'b1) mhi_hold++;
  end

  typedef struct packed {
    logic [7:0]      cmd;
    logic [2:0]      n;
    logic [0:2][7:0] d;
    logic [0:3][6:0] a_inc;   // expected strobe addresses, AUTO_INC=1
    logic [0:3][6:0] a_hold;  // expected strobe addresses, AUTO_INC=0
    logic [0:2][7:0] m_inc;   // expected MISO bytes (reads)
    logic [0:2][7:0] m_hold;
  } vec_t;

  vec_t vecs[7];
  int   n_vec = 0, n_err = 0;
  int   mb_inc, mb_hold, vb_inc, vb_hold;
  logic [7:0] mi_inc[3], mi_hold[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, output logic mi, output logic mh);
    mosi = b;
    #(hp);
    mi = bus_inc.MISO_toHost;
    mh = bus_hold.MISO_toHost;
    sclk = 1'b1;
    #(hp);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] mi, output logic [7:0] mh);
    logic x, y;
    mi = 8'h00;
    mh = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i], x, y);
      mi = {mi[6:0], x};
      mh = {mh[6:0], y};
    end
  endtask

  task automatic clear_frame();
    wq_inc.delete(); wq_hold.delete(); rq_inc.delete(); rq_hold.delete();
    mb_inc = mhi_inc; mb_hold = mhi_hold; vb_inc = viol_inc; vb_hold = viol_hold;
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input logic [2:0] n, input logic [0:2][7:0] d);
    logic [7:0] a, b;
    csn = 1'b0;
    #(hp);
    send_byte(cmd, a, b);
    for (int i = 0; i < int'(n); i++) begin
      send_byte(d[i], a, b);
      mi_inc[i]  = a;
      mi_hold[i] = b;
    end
    #(hp);
    csn  = 1'b1;
    mosi = 1'b0;
    #(120);
  endtask

  task automatic check_frame(input vec_t v);
    int nw, nr;
    nw = v.cmd[7] ? 0 : int'(v.n);
    nr = v.cmd[7] ? int'(v.n) + 1 : 0;
    chk($sformatf("wr_count_inc cmd=%h", v.cmd),  wq_inc.size(),  nw);
    chk($sformatf("wr_count_hold cmd=%h", v.cmd), wq_hold.size(), nw);
    chk($sformatf("rd_count_inc cmd=%h", v.cmd),  rq_inc.size(),  nr);
    chk($sformatf("rd_count_hold cmd=%h", v.cmd), rq_hold.size(), nr);
    for (int i = 0; i < nw; i++) begin
      if (i < wq_inc.size())
        chk($sformatf("wr_inc cmd=%h [%0d]", v.cmd, i), wq_inc[i], {v.a_inc[i], v.d[i]});
      if (i < wq_hold.size())
        chk($sformatf("wr_hold cmd=%h [%0d]", v.cmd, i), wq_hold[i], {v.a_hold[i], v.d[i]});
    end
    for (int i = 0; i < nr; i++) begin
      if (i < rq_inc.size())
        chk($sformatf("rd_inc cmd=%h [%0d]", v.cmd, i), rq_inc[i], v.a_inc[i]);
      if (i < rq_hold.size())
        chk($sformatf("rd_hold cmd=%h [%0d]", v.cmd, i), rq_hold[i], v.a_hold[i]);
    end
    if (v.cmd[7]) begin
      for (int i = 0; i < int'(v.n); i++) begin
        chk($sformatf("miso_inc cmd=%h [%0d]", v.cmd, i),  mi_inc[i],  v.m_inc[i]);
        chk($sformatf("miso_hold cmd=%h [%0d]", v.cmd, i), mi_hold[i], v.m_hold[i]);
      end
    end else begin
      chk("miso_quiet_inc",  mhi_inc - mb_inc,   0);
      chk("miso_quiet_hold", mhi_hold - mb_hold, 0);
    end
    chk("strobe_shape_inc",  viol_inc - vb_inc,   0);
    chk("strobe_shape_hold", viol_hold - vb_hold, 0);
  endtask

  task automatic run_vec(input vec_t v);
    clear_frame();
    spi_frame(v.cmd, v.n, v.d);
    check_frame(v);
  endtask

  function automatic vec_t model(input logic [7:0] c, input logic [2:0] n, input logic [0:2][7:0] d);
    vec_t v;
    logic [6:0] a;
    v = '0;
    v.cmd = c;
    v.n   = n;
    v.d   = d;
    for (int i = 0; i < 4; i++) begin
      a = c[6:0] + 7'(i);
      v.a_inc[i]  = a;
      v.a_hold[i] = c[6:0];
      if (i < 3) begin
        v.m_inc[i]  = ~{1'b0, a};
        v.m_hold[i] = ~{1'b0, c[6:0]};
      end
    end
    return v;
  endfunction

  initial begin
    logic [7:0] a, b;
    logic       x, y;

    vecs[0] = '{cmd: 8'h05, n: 3'd2, d: {8'hA5, 8'h3C, 8'h00},
                a_inc: {7'h05, 7'h06, 7'h00, 7'h00}, a_hold: {7'h05, 7'h05, 7'h00, 7'h00},
                m_inc: '0, m_hold: '0};
    vecs[1] = '{cmd: 8'h85, n: 3'd2, d: '0,
                a_inc: {7'h05, 7'h06, 7'h07, 7'h00}, a_hold: {7'h05, 7'h05, 7'h05, 7'h00},
                m_inc: {8'hFA, 8'hF9, 8'h00}, m_hold: {8'hFA, 8'hFA, 8'h00}};
    vecs[2] = '{cmd: 8'h7F, n: 3'd2, d: {8'h01, 8'h02, 8'h00},
                a_inc: {7'h7F, 7'h00, 7'h00, 7'h00}, a_hold: {7'h7F, 7'h7F, 7'h00, 7'h00},
                m_inc: '0, m_hold: '0};
    vecs[3] = '{cmd: 8'hFF, n: 3'd2, d: '0,
                a_inc: {7'h7F, 7'h00, 7'h01, 7'h00}, a_hold: {7'h7F, 7'h7F, 7'h7F, 7'h00},
                m_inc: {8'h80, 8'hFF, 8'h00}, m_hold: {8'h80, 8'h80, 8'h00}};
    vecs[4] = '{cmd: 8'h00, n: 3'd1, d: {8'h5A, 8'h00, 8'h00},
                a_inc: {7'h00, 7'h00, 7'h00, 7'h00}, a_hold: {7'h00, 7'h00, 7'h00, 7'h00},
                m_inc: '0, m_hold: '0};
    vecs[5] = '{cmd: 8'h80, n: 3'd3, d: '0,
                a_inc: {7'h00, 7'h01, 7'h02, 7'h03}, a_hold: {7'h00, 7'h00, 7'h00, 7'h00},
                m_inc: {8'hFF, 8'hFE, 8'hFD}, m_hold: {8'hFF, 8'hFF, 8'hFF}};
    vecs[6] = '{cmd: 8'h42, n: 3'd3, d: {8'h11, 8'h22, 8'h33},
                a_inc: {7'h42, 7'h43, 7'h44, 7'h00}, a_hold: {7'h42, 7'h42, 7'h42, 7'h00},
                m_inc: '0, m_hold: '0};

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("rst_frame_active", bus_inc.frame_active, 0);
    chk("rst_reg_addr",     bus_inc.reg_addr,     0);
    chk("rst_reg_wdata",    bus_inc.reg_wdata,    0);
    chk("rst_write_strobe", bus_inc.write_strobe, 0);
    chk("rst_read_strobe",  bus_inc.read_strobe,  0);
    chk("rst_miso",         bus_inc.MISO_toHost,  0);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);

    // Directed frame table
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Abort: command 0x10, five data bits, chip select released
    clear_frame();
    csn = 1'b0;
    #(hp);
    send_byte(8'h10, a, b);
    for (int i = 0; i < 5; i++) send_bit(i[0], x, y);
    #(hp);
    @(negedge clk);
    chk("abort_active_before", bus_inc.frame_active, 1);
    csn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_idle_inc",  bus_inc.frame_active,  0);
    chk("abort_idle_hold", bus_hold.frame_active, 0);
    #(120);
    chk("abort_no_wr_inc",  wq_inc.size(),  0);
    chk("abort_no_wr_hold", wq_hold.size(), 0);
    run_vec(model(8'h11, 3'd1, {8'h77, 8'h00, 8'h00}));

    // Reset asserted during data bit 3, released with chip select low
    clear_frame();
    csn = 1'b0;
    #(hp);
    send_byte(8'h20, a, b);
    for (int i = 0; i < 3; i++) send_bit(1'b1, x, y);
    mosi = 1'b0;
    #(hp);
    sclk = 1'b1;
    #(hp / 2);
    rst_n = 1'b0;
    #(hp / 2);
    sclk = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(1'b1, x, y);
    send_byte(8'hC3, a, b);
    #(hp);
    chk("rstmid_no_wr",        wq_inc.size() + wq_hold.size(), 0);
    chk("rstmid_no_rd",        rq_inc.size() + rq_hold.size(), 0);
    chk("rstmid_frame_active", bus_inc.frame_active, 0);
    chk("rstmid_reg_addr",     bus_inc.reg_addr,     0);
    chk("rstmid_reg_wdata",    bus_inc.reg_wdata,    0);
    chk("rstmid_miso",         bus_inc.MISO_toHost,  0);
    csn = 1'b1;
    #(120);
    run_vec(model(8'h21, 3'd1, {8'h99, 8'h00, 8'h00}));

    // 8:1 ratio, random phase, random frames
    hp = 40;
    for (int k = 0; k < 100; k++) begin
      logic [7:0]      c;
      logic [2:0]      n;
      logic [0:2][7:0] d;
      c = 8'($urandom);
      n = 3'($urandom_range(1, 3));
      d = 24'($urandom);
      #($urandom_range(0, 9));
      run_vec(model(c, n, d));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
